// File: rtl/fp16_to_fixed.sv
// fp16 -> unsigned fixed-point converter with a one-bit-per-cycle normalising shifter.
// Optional build macro FP2FX_ROUND_EN: round-to-nearest-even on right shifts (default: truncate).
module fp16_to_fixed #(
  parameter int FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat,
  output logic        out_neg,
  output logic        out_nan
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic signed [7:0] FB = 8'(FRAC_BITS);

  logic [1:0]    state, state_n;
  logic [W-1:0]  work, work_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          left, left_n;
  logic [W-1:0]  data_n;
  logic          sat_n, neg_n, nan_n;

  logic                sgn;
  logic [4:0]          expo;
  logic [9:0]          mant;
  logic [10:0]         sig;
  logic signed [7:0]   e, ef, k;
  logic [W-1:0]        shifted;

`ifdef FP2FX_ROUND_EN
  logic guard, guard_n, sticky, sticky_n;
`endif

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // Field decode and shift amount for the incoming sample
  always_comb begin
    sgn     = in_data[15];
    expo    = in_data[14:10];
    mant    = in_data[9:0];
    sig     = {expo != 5'd0, mant};
    e       = (expo == 5'd0) ? -8'sd14 : ($signed({3'b000, expo}) - 8'sd15);
    ef      = e + FB;
    k       = ef - 8'sd10;
    shifted = left ? (work << 1) : (work >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      left     <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
      out_neg  <= 1'b0;
      out_nan  <= 1'b0;
`ifdef FP2FX_ROUND_EN
      guard    <= 1'b0;
      sticky   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      work     <= work_n;
      cnt      <= cnt_n;
      left     <= left_n;
      out_data <= data_n;
      out_sat  <= sat_n;
      out_neg  <= neg_n;
      out_nan  <= nan_n;
`ifdef FP2FX_ROUND_EN
      guard    <= guard_n;
      sticky   <= sticky_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    work_n  = work;
    cnt_n   = cnt;
    left_n  = left;
    data_n  = out_data;
    sat_n   = out_sat;
    neg_n   = out_neg;
    nan_n   = out_nan;
`ifdef FP2FX_ROUND_EN
    guard_n  = guard;
    sticky_n = sticky;
`endif
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_n = DONE;
          data_n  = '0;
          if (expo == 5'd31 && mant != 10'd0) begin
            nan_n = 1'b1;
          end else if (sgn) begin
            neg_n = 1'b1;
          end else if (expo == 5'd31) begin
            data_n = 16'hFFFF;
            sat_n  = 1'b1;
          end else if (expo == 5'd0 && mant == 10'd0) begin
            data_n = '0;
          end else if (ef >= 8'sd16) begin
            data_n = 16'hFFFF;
            sat_n  = 1'b1;
          end else if (k <= -8'sd11) begin
            data_n = '0;
          end else begin
            work_n = W'(sig);
            cnt_n  = k[7] ? CW'(-k) : CW'(k);
            left_n = !k[7];
`ifdef FP2FX_ROUND_EN
            guard_n  = 1'b0;
            sticky_n = 1'b0;
`endif
            if (k == 8'sd0) data_n = W'(sig);
            else            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_n = shifted;
        cnt_n  = cnt - CW'(1);
`ifdef FP2FX_ROUND_EN
        guard_n  = left ? 1'b0 : work[0];
        sticky_n = sticky | guard;
`endif
        if (cnt == CW'(1)) begin
          state_n = DONE;
          data_n  = shifted;
`ifdef FP2FX_ROUND_EN
          // Guard is the last bit shifted out; sticky is the OR of all earlier ones
          if (guard_n && (sticky_n || shifted[0])) begin
            if (shifted == 16'hFFFF) sat_n = 1'b1;
            else                     data_n = shifted + 16'd1;
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
          data_n  = '0;
          sat_n   = 1'b0;
          neg_n   = 1'b0;
          nan_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Randomised self-checking bench for fp16_to_fixed: FRAC_BITS=0 and FRAC_BITS=8 instances
// compared against an arithmetic reference model.
module tb_fp16_to_fixed;

  logic        clk;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_data  [2];
  logic        out_sat   [2];
  logic        out_neg   [2];
  logic        out_nan   [2];

  int n_tests = 0;
  int n_fail  = 0;

  fp16_to_fixed #(.FRAC_BITS(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_sat(out_sat[0]), .out_neg(out_neg[0]), .out_nan(out_nan[0])
  );

  fp16_to_fixed #(.FRAC_BITS(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_sat(out_sat[1]), .out_neg(out_neg[1]), .out_nan(out_nan[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Value = sig * 2^(e-10); scaled result = sig * 2^(e + fb - 10). flags = {sat, neg, nan}
  function automatic void ref_model(input int fb, input logic [15:0] din,
                                    output logic [15:0] d, output logic [2:0] fl,
                                    output int lat);
    int ex, mt, e, k, s;
    longint sig, q, rem, half;
    ex  = int'(din[14:10]);
    mt  = int'(din[9:0]);
    d   = 16'h0;
    fl  = 3'b000;
    lat = 1;
    if (ex == 31 && mt != 0) fl = 3'b001;
    else if (din[15]) fl = 3'b010;
    else if (ex == 31) begin d = 16'hFFFF; fl = 3'b100; end
    else if (ex == 0 && mt == 0) d = 16'h0;
    else begin
      sig = (ex != 0) ? longint'(1024 + mt) : longint'(mt);
      e   = (ex != 0) ? ex - 15 : -14;
      k   = e + fb - 10;
      if (e + fb >= 16) begin d = 16'hFFFF; fl = 3'b100; end
      else if (k <= -11) d = 16'h0;
      else begin
        lat = 1 + ((k < 0) ? -k : k);
        if (k >= 0) q = sig * (longint'(1) << k);
        else begin
          s    = -k;
          q    = sig / (longint'(1) << s);
          rem  = sig % (longint'(1) << s);
          half = longint'(1) << (s - 1);
`ifdef FP2FX_ROUND_EN
          if (rem > half || (rem == half && q % 2 == 1)) q = q + 1;
`else
          if (rem < 0 || half < 0) q = 0;
`endif
        end
        if (q > 65535) begin d = 16'hFFFF; fl = 3'b100; end
        else d = 16'(q);
      end
    end
  endfunction

  task automatic run(input int idx, input logic [15:0] din, input int hold,
                     output logic [15:0] gd, output logic [2:0] gf, output int glat);
    logic [15:0] rd;
    logic [2:0]  rf;
    int          rl;
    ref_model((idx != 0) ? 8 : 0, din, rd, rf, rl);
    check("in_ready_idle", 32'(in_ready[idx]), 32'd1);
    in_valid[idx] = 1'b1;
    in_data[idx]  = din;
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    glat = 1;
    while (!out_valid[idx] && glat < 40) begin
      @(posedge clk); #1;
      glat++;
    end
    check("out_valid_timeout", 32'(out_valid[idx]), 32'd1);
    gd = out_data[idx];
    gf = {out_sat[idx], out_neg[idx], out_nan[idx]};
    check($sformatf("lat_%04h", din), 32'(glat), 32'(rl));
    check($sformatf("data_%04h", din), 32'(gd), 32'(rd));
    check($sformatf("flags_%04h", din), 32'(gf), 32'(rf));
    if (hold > 0) begin
      in_valid[idx] = 1'b1;
      in_data[idx]  = 16'h3C00;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("bp_valid", 32'(out_valid[idx]), 32'd1);
        check("bp_data", 32'(out_data[idx]), 32'(rd));
        check("bp_flags", 32'({out_sat[idx], out_neg[idx], out_nan[idx]}), 32'(rf));
        check("bp_in_ready", 32'(in_ready[idx]), 32'd0);
      end
    end
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
    in_valid[idx]  = 1'b0;
    check("handoff_valid_low", 32'(out_valid[idx]), 32'd0);
    check("handoff_in_ready", 32'(in_ready[idx]), 32'd1);
  endtask

  task automatic directed(input int idx, input logic [15:0] din, input int hold,
                          input logic [15:0] d, input logic [2:0] f, input int lat);
    logic [15:0] gd;
    logic [2:0]  gf;
    int          gl;
    run(idx, din, hold, gd, gf, gl);
    check($sformatf("dir_data_%0d_%04h", idx, din), 32'(gd), 32'(d));
    check($sformatf("dir_flags_%0d_%04h", idx, din), 32'(gf), 32'(f));
    check($sformatf("dir_lat_%0d_%04h", idx, din), 32'(gl), 32'(lat));
  endtask

`ifdef FP2FX_ROUND_EN
  localparam logic [15:0] R_1P5 = 16'd2;
`else
  localparam logic [15:0] R_1P5 = 16'd1;
`endif

  initial begin
    logic [15:0] gd, din;
    logic [2:0]  gf;
    int          gl, idx;
    logic        seen;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = 16'h0; out_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", 32'(in_ready[i]), 32'd0);
      check("rst_out_valid", 32'(out_valid[i]), 32'd0);
      check("rst_out_data", 32'(out_data[i]), 32'd0);
      check("rst_flags", 32'({out_sat[i], out_neg[i], out_nan[i]}), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);

    // Abort mid-shift: reset must kill the pending result
    in_valid[0] = 1'b1; in_data[0] = 16'h3C00;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_shift_in_ready", 32'(in_ready[0]), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_in_ready_rst", 32'(in_ready[0]), 32'd0);
    check("abort_valid_rst", 32'(out_valid[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_in_ready_after", 32'(in_ready[0]), 32'd1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen = 1'b1;
    end
    check("abort_no_output", 32'(seen), 32'd0);

    directed(0, 16'h3C00, 0, 16'd1,    3'b000, 11);
    directed(0, 16'h4E40, 0, 16'd25,   3'b000, 7);
    directed(0, 16'h7BFF, 0, 16'hFFE0, 3'b000, 6);
    directed(0, 16'h7C00, 0, 16'hFFFF, 3'b100, 1);
    directed(0, 16'hBC00, 0, 16'h0000, 3'b010, 1);
    directed(0, 16'h7E00, 0, 16'h0000, 3'b001, 1);
    directed(0, 16'h0001, 0, 16'h0000, 3'b000, 1);
    directed(0, 16'h8000, 0, 16'h0000, 3'b010, 1);
    directed(0, 16'h6400, 0, 16'd1024, 3'b000, 1);
    directed(1, 16'h3E00, 0, 16'h0180, 3'b000, 3);
    directed(1, 16'h5C00, 0, 16'hFFFF, 3'b100, 1);
    directed(0, 16'h3E00, 0, R_1P5,    3'b000, 11);
    directed(0, 16'h4100, 0, 16'd2,    3'b000, 10);
    directed(0, 16'h4E40, 5, 16'd25,   3'b000, 7);
    directed(1, 16'h7C00, 5, 16'hFFFF, 3'b100, 1);

    for (int n = 0; n < 200; n++) begin
      idx = int'($urandom_range(1, 0));
      if ($urandom_range(1, 0) == 0) din = 16'($urandom);
      else din = {1'b0, 5'($urandom_range(25, 3)), 10'($urandom)};
      run(idx, din, int'($urandom_range(3, 0)), gd, gf, gl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
